rifl_gt_reset_ctrl: RTL and testbench
=====================================

Name: rifl_gt_reset_ctrl

Overview:
Multi-lane GT bring-up and recovery controller in the init_clk domain. It generalises the single-counter datapath reset scheme to N_CHANNEL lanes:
- global all-reset with TX timeout
- per-lane RX datapath reset with its own timeout and retry budget
- escalation to a full reset when any lane exhausts its retries
- link-up tracking with automatic recovery on loss

It drives gtwiz_reset_all_in and the per-lane RX datapath resets of the GT core wrapper.

Parameters:
N_CHANNEL, 1, number of GT lanes
ALL_TIMEOUT_W, 20, TX-good wait counter width; timeout at count 2**ALL_TIMEOUT_W-1
RX_TIMEOUT_W, 23, per-lane RX-good wait counter width; timeout at all-ones
PULSE_CYCLES, 16, width in clk cycles of every reset pulse issued (>=1)
MAX_RX_RETRY, 4, per-lane RX resets allowed before escalating to all-reset (>=1)

Ports:
clk  in  1  free-running init clock
rst_n  in  1  asynchronous active-low reset
gt_init_rst  in  1  synchronous active-high user reset request
tx_good  in  1  TX reset done & buffbypass done, already synced to clk
rx_good  in  N_CHANNEL  per-lane RX reset done & bypass done & aligned, synced to clk
rst_all_out  out  1  to gtwiz_reset_all_in
rst_rx_datapath_out  out  N_CHANNEL  per-lane RX datapath reset
link_up  out  1  all lanes good and TX good
state_out  out  3  FSM state encoding, for debug

Behaviour:
- One clock. Reset is asynchronous and active-low on rst_n. All flops clear on rst_n low.
- Values during reset and after release:
  - rst_all_out=1
  - rst_rx_datapath_out=0
  - link_up=0
  - state=RST_ALL with pulse counter 0
- FSM states and encodings: RST_ALL(0), WAIT_TX(1), WAIT_RX(2), UP(3).
- RST_ALL:
  - rst_all_out=1 for exactly PULSE_CYCLES cycles, then go to WAIT_TX.
  - On entry, clear all lane retry counters, lane-done flags and timeout counters.
  - While gt_init_rst=1, hold the pulse counter at 0, so the pulse ends PULSE_CYCLES cycles after gt_init_rst falls.
- WAIT_TX:
  - rst_all_out=0; the TX counter increments each cycle.
  - tx_good=1: go to WAIT_RX and clear the counter.
  - Counter reaches all-ones with tx_good=0: go to RST_ALL. Timeout takes priority only if tx_good=0 in that same cycle.
- WAIT_RX: per-lane sub-machine for each lane i, states WAIT / PULSE / DONE.
  - WAIT: rx counter increments. rx_good[i]=1 moves the lane to DONE. All-ones moves the lane to PULSE and increments retry[i].
  - PULSE: rst_rx_datapath_out[i]=1 for PULSE_CYCLES cycles, then back to WAIT with the counter cleared. rx_good is ignored during PULSE.
  - DONE: if rx_good[i] falls, the lane returns to WAIT with its counter cleared.
  - Any retry[i] reaching MAX_RX_RETRY: go to RST_ALL on the next cycle. This overrides lane progress.
  - All lanes DONE in the same cycle: go to UP.
- UP:
  - link_up=1, registered, asserted the cycle after entry.
  - tx_good falling: go to RST_ALL.
  - Any rx_good[i] falling: that lane goes to WAIT, state goes to WAIT_RX, link_up=0 the next cycle. Retry counters are not cleared; they clear only in RST_ALL.
- gt_init_rst=1 in any state: go to RST_ALL next cycle. Highest priority below rst_n.
- Simultaneous events:
  - tx_good loss beats rx_good loss.
  - In WAIT_RX, escalation beats all-lanes-done.
- Retry counters saturate at MAX_RX_RETRY. Width is $clog2(MAX_RX_RETRY+1).
- Timeout counters never wrap. The all-ones compare is registered into the transition in the same cycle the count hits all-ones.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
RIFL_RESET_STATS_EN
- Defined:
  - Adds output all_reset_cnt[15:0]: count of RST_ALL entries caused by timeout, escalation or link loss. gt_init_rst and rst_n entries are not counted.
  - Adds output rx_reset_cnt[16*N_CHANNEL-1:0]: per-lane count of RX datapath pulses.
  - Both saturate at 16'hFFFF and clear only on rst_n.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
All scenarios use N_CHANNEL=2, ALL_TIMEOUT_W=4, RX_TIMEOUT_W=5, PULSE_CYCLES=4, MAX_RX_RETRY=2.
1. Release rst_n; tx_good=1 at cycle 6; rx_good=2'b11 at cycle 10 -> rst_all_out high for cycles 0-3, state WAIT_TX at 4, WAIT_RX at 7, link_up=1 at cycle 12.
2. tx_good held 0 -> rst_all_out re-pulses for 4 cycles after 15 WAIT_TX cycles; this repeats indefinitely; link_up stays 0.
3. tx_good=1, rx_good[0]=1, rx_good[1]=0 -> lane 1 pulse (4 cycles) after 31 wait cycles. After the 2nd timeout: RST_ALL, retry counters cleared, lane 0 never pulsed.
4. In UP, drop rx_good[1] for 1 cycle -> link_up=0 next cycle, state WAIT_RX, no rst_all_out. Restore -> link_up=1 two cycles later.
5. Assert gt_init_rst in WAIT_RX for 10 cycles -> rst_all_out high throughout plus 4 cycles after release; all rst_rx_datapath_out bits forced 0.
6. Assert rst_n low mid-PULSE on lane 0 -> immediate rst_all_out=1, rst_rx_datapath_out=0, link_up=0. With RIFL_RESET_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/rifl_gt_reset_ctrl.sv
// rtl/rifl_gt_reset_ctrl.sv - multi-lane GT bring-up / recovery reset controller
// Optional statistics counters: define RIFL_RESET_STATS_EN.
module rifl_gt_reset_ctrl #(
  parameter int unsigned N_CHANNEL     = 1,
  parameter int unsigned ALL_TIMEOUT_W = 20,
  parameter int unsigned RX_TIMEOUT_W  = 23,
  parameter int unsigned PULSE_CYCLES  = 16,
  parameter int unsigned MAX_RX_RETRY  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gt_init_rst,
  input  logic                   tx_good,
  input  logic [N_CHANNEL-1:0]   rx_good,
  output logic                   rst_all_out,
  output logic [N_CHANNEL-1:0]   rst_rx_datapath_out,
  output logic                   link_up,
  output logic [2:0]             state_out
`ifdef RIFL_RESET_STATS_EN
  ,
  output logic [15:0]            all_reset_cnt,
  output logic [16*N_CHANNEL-1:0] rx_reset_cnt
`endif
);

  localparam int unsigned PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned RTW = $clog2(MAX_RX_RETRY + 1);

  // Counters transition on the cycle that would carry them to all-ones,
  // so the counter reaches all-ones on the same edge the state changes.
  localparam logic [ALL_TIMEOUT_W-1:0] TX_LAST    = ~ALL_TIMEOUT_W'(1);
  localparam logic [RX_TIMEOUT_W-1:0]  RX_LAST    = ~RX_TIMEOUT_W'(1);
  localparam logic [PW-1:0]            PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [RTW-1:0]           RETRY_MAX  = RTW'(MAX_RX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_ALL = 3'd0,
    ST_WAIT_TX = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_UP      = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    LN_WAIT  = 2'd0,
    LN_PULSE = 2'd1,
    LN_DONE  = 2'd2
  } lane_t;

  state_t                   state, state_nxt;
  logic [PW-1:0]            all_pcnt;
  logic [ALL_TIMEOUT_W-1:0] tx_cnt;

  lane_t                    lane_st     [N_CHANNEL];
  lane_t                    lane_nxt    [N_CHANNEL];
  logic [RX_TIMEOUT_W-1:0]  rx_cnt      [N_CHANNEL];
  logic [RX_TIMEOUT_W-1:0]  rx_cnt_nxt  [N_CHANNEL];
  logic [PW-1:0]            ln_pcnt     [N_CHANNEL];
  logic [PW-1:0]            ln_pcnt_nxt [N_CHANNEL];
  logic [RTW-1:0]           retry       [N_CHANNEL];
  logic [RTW-1:0]           retry_nxt   [N_CHANNEL];
  logic [N_CHANNEL-1:0]     pulse_start;

  logic                     any_esc;
  logic                     all_done;
  logic                     lane_run;
  logic                     rst_all_d;
  logic                     link_up_d;
  logic [N_CHANNEL-1:0]     rst_rx_d;

  assign state_out = state;

  // Per-lane RX sub-machine: wait for rx_good, time out into a datapath pulse
  always_comb begin
    any_esc     = 1'b0;
    all_done    = 1'b1;
    pulse_start = '0;
    for (int i = 0; i < int'(N_CHANNEL); i++) begin
      lane_nxt[i]    = lane_st[i];
      rx_cnt_nxt[i]  = rx_cnt[i];
      ln_pcnt_nxt[i] = ln_pcnt[i];
      retry_nxt[i]   = retry[i];
      case (lane_st[i])
        LN_WAIT: begin
          if (rx_good[i]) begin
            lane_nxt[i]   = LN_DONE;
            rx_cnt_nxt[i] = '0;
          end else if (rx_cnt[i] == RX_LAST) begin
            lane_nxt[i]    = LN_PULSE;
            rx_cnt_nxt[i]  = '0;
            ln_pcnt_nxt[i] = '0;
            pulse_start[i] = 1'b1;
            retry_nxt[i]   = (retry[i] == RETRY_MAX) ? retry[i] : retry[i] + 1'b1;
          end else begin
            rx_cnt_nxt[i] = rx_cnt[i] + 1'b1;
          end
        end
        LN_PULSE: begin
          if (ln_pcnt[i] == PULSE_LAST) begin
            lane_nxt[i]    = LN_WAIT;
            rx_cnt_nxt[i]  = '0;
            ln_pcnt_nxt[i] = '0;
          end else begin
            ln_pcnt_nxt[i] = ln_pcnt[i] + 1'b1;
          end
        end
        LN_DONE: begin
          if (!rx_good[i]) begin
            lane_nxt[i]   = LN_WAIT;
            rx_cnt_nxt[i] = '0;
          end
        end
        default: begin
          lane_nxt[i]   = LN_WAIT;
          rx_cnt_nxt[i] = '0;
        end
      endcase
      if (retry_nxt[i] == RETRY_MAX) any_esc = 1'b1;
      if (lane_nxt[i] != LN_DONE)    all_done = 1'b0;
    end
  end

  // Top-level next state; gt_init_rst dominates, then loss/escalation events
  always_comb begin
    state_nxt = state;
    if (gt_init_rst) begin
      state_nxt = ST_RST_ALL;
    end else begin
      case (state)
        ST_RST_ALL: if (all_pcnt == PULSE_LAST) state_nxt = ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_good)                  state_nxt = ST_WAIT_RX;
          else if (tx_cnt == TX_LAST)   state_nxt = ST_RST_ALL;
        end
        ST_WAIT_RX: begin
          if (any_esc)       state_nxt = ST_RST_ALL;
          else if (all_done) state_nxt = ST_UP;
        end
        ST_UP: begin
          if (!tx_good)       state_nxt = ST_RST_ALL;
          else if (!all_done) state_nxt = ST_WAIT_RX;
        end
        default: state_nxt = ST_RST_ALL;
      endcase
    end
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    lane_run  = (state == ST_WAIT_RX || state == ST_UP) &&
                (state_nxt == ST_WAIT_RX || state_nxt == ST_UP);
    rst_all_d = (state_nxt == ST_RST_ALL);
    link_up_d = (state == ST_UP) && (state_nxt == ST_UP);
    rst_rx_d  = '0;
    for (int i = 0; i < int'(N_CHANNEL); i++) begin
      rst_rx_d[i] = lane_run && (lane_nxt[i] == LN_PULSE);
    end
  end

  // State, counters, lane machines and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_RST_ALL;
      all_pcnt            <= '0;
      tx_cnt              <= '0;
      rst_all_out         <= 1'b1;
      rst_rx_datapath_out <= '0;
      link_up             <= 1'b0;
      for (int i = 0; i < int'(N_CHANNEL); i++) begin
        lane_st[i] <= LN_WAIT;
        rx_cnt[i]  <= '0;
        ln_pcnt[i] <= '0;
        retry[i]   <= '0;
      end
    end else begin
      state               <= state_nxt;
      rst_all_out         <= rst_all_d;
      rst_rx_datapath_out <= rst_rx_d;
      link_up             <= link_up_d;
      // Pulse count restarts while gt_init_rst is held, stretching the pulse
      if (state == ST_RST_ALL && state_nxt == ST_RST_ALL && !gt_init_rst)
        all_pcnt <= all_pcnt + 1'b1;
      else
        all_pcnt <= '0;
      if (state == ST_WAIT_TX && state_nxt == ST_WAIT_TX)
        tx_cnt <= tx_cnt + 1'b1;
      else
        tx_cnt <= '0;
      // Lanes only run while the link is being brought up or is up; leaving
      // that region always passes through RST_ALL, which clears retries.
      for (int i = 0; i < int'(N_CHANNEL); i++) begin
        if (lane_run) begin
          lane_st[i] <= lane_nxt[i];
          rx_cnt[i]  <= rx_cnt_nxt[i];
          ln_pcnt[i] <= ln_pcnt_nxt[i];
          retry[i]   <= retry_nxt[i];
        end else begin
          lane_st[i] <= LN_WAIT;
          rx_cnt[i]  <= '0;
          ln_pcnt[i] <= '0;
          retry[i]   <= '0;
        end
      end
    end
  end

`ifdef RIFL_RESET_STATS_EN
  // Saturating recovery statistics; user-requested resets are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_reset_cnt <= '0;
      rx_reset_cnt  <= '0;
    end else begin
      if (state != ST_RST_ALL && state_nxt == ST_RST_ALL && !gt_init_rst &&
          all_reset_cnt != 16'hFFFF)
        all_reset_cnt <= all_reset_cnt + 16'd1;
      for (int i = 0; i < int'(N_CHANNEL); i++) begin
        if (lane_run && pulse_start[i] && rx_reset_cnt[16*i +: 16] != 16'hFFFF)
          rx_reset_cnt[16*i +: 16] <= rx_reset_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rifl_gt_reset_ctrl.sv
// tb/tb_rifl_gt_reset_ctrl.sv - directed self-checking bench for rifl_gt_reset_ctrl
module tb_rifl_gt_reset_ctrl;

  logic       clk;
  logic       rst_n;
  logic       gt_init_rst;
  logic       tx_good;
  logic [1:0] rx_good;
  logic       rst_all_out;
  logic [1:0] rst_rx_datapath_out;
  logic       link_up;
  logic [2:0] state_out;
`ifdef RIFL_RESET_STATS_EN
  logic [15:0] all_reset_cnt;
  logic [31:0] rx_reset_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rifl_gt_reset_ctrl #(
    .N_CHANNEL    (2),
    .ALL_TIMEOUT_W(4),
    .RX_TIMEOUT_W (5),
    .PULSE_CYCLES (4),
    .MAX_RX_RETRY (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .gt_init_rst        (gt_init_rst),
    .tx_good            (tx_good),
    .rx_good            (rx_good),
    .rst_all_out        (rst_all_out),
    .rst_rx_datapath_out(rst_rx_datapath_out),
    .link_up            (link_up),
    .state_out          (state_out)
`ifdef RIFL_RESET_STATS_EN
    ,
    .all_reset_cnt      (all_reset_cnt),
    .rx_reset_cnt       (rx_reset_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    gt_init_rst = 1'b0;
    tx_good     = 1'b0;
    rx_good     = 2'b00;
    @(negedge clk);

    // Normal bring-up
    do_reset();
    chk("rst_rx_reset", 32'(rst_rx_datapath_out), 32'd0);
    for (int c = 0; c <= 13; c++) begin
      chk("s1_state",   32'(state_out),   (c <= 3) ? 32'd0 : (c <= 6) ? 32'd1 : (c <= 10) ? 32'd2 : 32'd3);
      chk("s1_rst_all", 32'(rst_all_out), (c <= 3) ? 32'd1 : 32'd0);
      chk("s1_link",    32'(link_up),     (c >= 12) ? 32'd1 : 32'd0);
      chk("s1_rst_rx",  32'(rst_rx_datapath_out), 32'd0);
      if (c == 6)  tx_good = 1'b1;
      if (c == 10) rx_good = 2'b11;
      step();
    end

    // Single-cycle lane loss in UP and recovery
    rx_good = 2'b01;
    step();
    chk("s4_link_drop", 32'(link_up),     32'd0);
    chk("s4_state_rx",  32'(state_out),   32'd2);
    chk("s4_no_rstall", 32'(rst_all_out), 32'd0);
    rx_good = 2'b11;
    step();
    chk("s4_state_up",  32'(state_out),   32'd3);
    chk("s4_link_lag",  32'(link_up),     32'd0);
    step();
    chk("s4_link_back", 32'(link_up),     32'd1);
    chk("s4_no_rstall2", 32'(rst_all_out), 32'd0);

    // User reset held for 10 cycles while in WAIT_RX
    rx_good = 2'b00;
    step();
    chk("s5_state_rx", 32'(state_out), 32'd2);
    gt_init_rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("s5_rst_all_hold", 32'(rst_all_out), 32'd1);
      chk("s5_state_hold",   32'(state_out),   32'd0);
      chk("s5_rst_rx_hold",  32'(rst_rx_datapath_out), 32'd0);
      if (k == 10) gt_init_rst = 1'b0;
    end
    for (int k = 11; k <= 14; k++) begin
      step();
      chk("s5_rst_all_tail", 32'(rst_all_out), (k <= 13) ? 32'd1 : 32'd0);
      chk("s5_state_tail",   32'(state_out),   (k <= 13) ? 32'd0 : 32'd1);
    end

    // TX never good: periodic all-reset
    tx_good = 1'b0;
    rx_good = 2'b00;
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      chk("s2_rst_all", 32'(rst_all_out), ((c % 19) <= 3) ? 32'd1 : 32'd0);
      chk("s2_state",   32'(state_out),   ((c % 19) <= 3) ? 32'd0 : 32'd1);
      chk("s2_link",    32'(link_up),     32'd0);
      step();
    end
`ifdef RIFL_RESET_STATS_EN
    chk("s2_all_reset_cnt", 32'(all_reset_cnt), 32'd3);
`endif

    // tx_good arriving on the timeout cycle wins
    do_reset();
    repeat (18) step();
    chk("s2b_state_tx", 32'(state_out), 32'd1);
    tx_good = 1'b1;
    step();
    chk("s2b_good_wins", 32'(state_out), 32'd2);
    chk("s2b_no_rstall", 32'(rst_all_out), 32'd0);

    // Lane 1 never good: two timeouts, escalation, retries cleared
    tx_good = 1'b1;
    rx_good = 2'b01;
    do_reset();
    for (int c = 0; c <= 115; c++) begin
      chk("s3_state", 32'(state_out),
          (c <= 3) ? 32'd0 : (c == 4) ? 32'd1 : (c <= 70) ? 32'd2 :
          (c <= 74) ? 32'd0 : (c == 75) ? 32'd1 : 32'd2);
      chk("s3_rst_all", 32'(rst_all_out), (c <= 3 || (c >= 71 && c <= 74)) ? 32'd1 : 32'd0);
      chk("s3_rst_rx",  32'(rst_rx_datapath_out),
          ((c >= 36 && c <= 39) || (c >= 107 && c <= 110)) ? 32'd2 : 32'd0);
      chk("s3_link",    32'(link_up), 32'd0);
      step();
    end
`ifdef RIFL_RESET_STATS_EN
    chk("s3_all_reset_cnt", 32'(all_reset_cnt), 32'd1);
    chk("s3_rx_reset_cnt",  rx_reset_cnt, {16'd2, 16'd0});
`endif

    // Asynchronous reset in the middle of a lane 0 pulse
    rx_good = 2'b10;
    do_reset();
    repeat (37) step();
    chk("s6_mid_pulse", 32'(rst_rx_datapath_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_all", 32'(rst_all_out), 32'd1);
    chk("s6_rst_rx",  32'(rst_rx_datapath_out), 32'd0);
    chk("s6_link",    32'(link_up), 32'd0);
    chk("s6_state",   32'(state_out), 32'd0);
`ifdef RIFL_RESET_STATS_EN
    chk("s6_all_reset_cnt", 32'(all_reset_cnt), 32'd0);
    chk("s6_rx_reset_cnt",  rx_reset_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
